clock_tester_multi: RTL and testbench

- Multi-channel successor of the single-channel clock tester. Measures high time, low time and period of NUM_CH slow clocks, in cycles of one fast reference clock.
- Adds per-channel input synchronisers, counter saturation, period min/max tracking and stopped-clock detection. Results are read out through a registered channel-select mux.
- Sits beside the MMCM DRP/AXI logic to verify reprogrammed output frequencies and duty cycles.

---
 rtl/clock_tester_multi.sv | 189 ++++++++++++++++++
 tb/tb_clock_tester_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tester_multi.sv
// Multi-channel slow-clock tester: per-channel high/low/period measurement in fast-clock
// cycles, with saturation, period min/max, stopped detection and a registered readout mux.

module clock_tester_ch #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_fst,
  input  logic             clr_i,
  input  logic             armed_i,
  input  logic             slw_i,
  output logic [CNT_W-1:0] ht_o,
  output logic [CNT_W-1:0] lt_o,
  output logic [CNT_W:0]   per_o,
  output logic [CNT_W:0]   min_o,
  output logic [CNT_W:0]   max_o,
  output logic             vld_o,
  output logic             upd_o,
  output logic             stopped_o
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [IW-1:0]    TMO  = IW'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_q, s, rise, fall;
  logic [CNT_W-1:0]       hcnt_q, lcnt_q, ht_q, lt_q;
  logic [CNT_W:0]         per_q, min_q, max_q, per_new;
  logic                   seen_r_q, seen_f_q, hi_seen_q, vld_q, upd_q;
  logic [IW-1:0]          idle_q;

  assign s       = sync_q[SYNC_STAGES-1];
  // edges are ignored until the synchroniser and delay flop hold real samples
  assign rise    = armed_i & ~d_q & s;
  assign fall    = armed_i & d_q & ~s;
  assign per_new = {1'b0, ht_q} + {1'b0, lcnt_q};

  always_ff @(posedge clk_fst) begin
    if (clr_i) begin
      sync_q    <= '0;
      d_q       <= 1'b0;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      ht_q      <= '0;
      lt_q      <= '0;
      per_q     <= '0;
      min_q     <= '1;
      max_q     <= '0;
      seen_r_q  <= 1'b0;
      seen_f_q  <= 1'b0;
      hi_seen_q <= 1'b0;
      vld_q     <= 1'b0;
      upd_q     <= 1'b0;
      idle_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slw_i};
      d_q    <= s;
      upd_q  <= 1'b0;
      if (rise || fall)                idle_q <= '0;
      else if (armed_i && idle_q != TMO) idle_q <= idle_q + 1'b1;
      if (fall) begin
        // a high phase counts only if it started on an observed rise
        if (seen_r_q) ht_q <= hcnt_q;
        hi_seen_q <= seen_r_q;
        seen_f_q  <= 1'b1;
        hcnt_q    <= '0;
        lcnt_q    <= CNT_W'(1);
      end else if (rise) begin
        if (seen_f_q) lt_q <= lcnt_q;
        if (hi_seen_q) begin
          per_q <= per_new;
          upd_q <= 1'b1;
          vld_q <= 1'b1;
          if (!vld_q || per_new < min_q) min_q <= per_new;
          if (!vld_q || per_new > max_q) max_q <= per_new;
        end
        seen_r_q <= 1'b1;
        lcnt_q   <= '0;
        hcnt_q   <= CNT_W'(1);
      end else if (armed_i) begin
        if (d_q && s && hcnt_q != CMAX)   hcnt_q <= hcnt_q + 1'b1;
        if (!d_q && !s && lcnt_q != CMAX) lcnt_q <= lcnt_q + 1'b1;
      end
    end
  end

  assign ht_o      = ht_q;
  assign lt_o      = lt_q;
  assign per_o     = per_q;
  assign min_o     = min_q;
  assign max_o     = max_q;
  assign vld_o     = vld_q;
  assign upd_o     = upd_q;
  assign stopped_o = (idle_q == TMO);
endmodule

module clock_tester_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int SEL_W       = 2
) (
  input  logic              clk_fst,
  input  logic              reset,
  input  logic              restart,
  input  logic [NUM_CH-1:0] clk_slw,
  input  logic [SEL_W-1:0]  ch_sel,
  output logic [CNT_W-1:0]  ht_out,
  output logic [CNT_W-1:0]  lt_out,
  output logic [CNT_W:0]    per_out,
  output logic [CNT_W:0]    per_min,
  output logic [CNT_W:0]    per_max,
  output logic              valid_out,
  output logic [NUM_CH-1:0] stopped,
  output logic [NUM_CH-1:0] upd
);
  localparam int NSEL = 2**SEL_W;

  logic                         clr;
  logic [SYNC_STAGES:0]         vld_pipe;
  logic [NUM_CH-1:0][CNT_W-1:0] ht_c, lt_c;
  logic [NUM_CH-1:0][CNT_W:0]   per_c, min_c, max_c;
  logic [NUM_CH-1:0]            vld_c;
  logic [NSEL-1:0][CNT_W-1:0]   ht_a, lt_a;
  logic [NSEL-1:0][CNT_W:0]     per_a, min_a, max_a;
  logic [NSEL-1:0]              vld_a;

  assign clr = reset | restart;

  // fills one stage per cycle after clear; top bit marks d/s as trustworthy
  always_ff @(posedge clk_fst) begin
    if (clr) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
  end

  clock_tester_ch #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) u_ch [NUM_CH-1:0] (
    .clk_fst  (clk_fst),
    .clr_i    (clr),
    .armed_i  (vld_pipe[SYNC_STAGES]),
    .slw_i    (clk_slw),
    .ht_o     (ht_c),
    .lt_o     (lt_c),
    .per_o    (per_c),
    .min_o    (min_c),
    .max_o    (max_c),
    .vld_o    (vld_c),
    .upd_o    (upd),
    .stopped_o(stopped)
  );

  // selector space padded to 2**SEL_W so unused codes read as zero
  for (genvar i = 0; i < NSEL; i++) begin : g_sel
    if (i < NUM_CH) begin : g_ch
      assign ht_a[i]  = ht_c[i];
      assign lt_a[i]  = lt_c[i];
      assign per_a[i] = per_c[i];
      assign min_a[i] = min_c[i];
      assign max_a[i] = max_c[i];
      assign vld_a[i] = vld_c[i];
    end else begin : g_zero
      assign ht_a[i]  = '0;
      assign lt_a[i]  = '0;
      assign per_a[i] = '0;
      assign min_a[i] = '0;
      assign max_a[i] = '0;
      assign vld_a[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_fst) begin
    if (clr) begin
      ht_out    <= '0;
      lt_out    <= '0;
      per_out   <= '0;
      per_min   <= '1;
      per_max   <= '0;
      valid_out <= 1'b0;
    end else begin
      ht_out    <= ht_a[ch_sel];
      lt_out    <= lt_a[ch_sel];
      per_out   <= per_a[ch_sel];
      per_min   <= min_a[ch_sel];
      per_max   <= max_a[ch_sel];
      valid_out <= vld_a[ch_sel];
    end
  end
endmodule

// File: tb/tb_clock_tester_multi.sv
// Bench for clock_tester_multi: random slow clocks checked against an edge-timestamp model.
`timescale 1ns/1ps
module tb_clock_tester_multi;
  localparam int NCH = 4, CW = 8, SS = 2, TMO = 64, SW = 2;
  localparam int SMAX = 255, PMAX = 511;

  logic          clk_fst = 1'b0, reset = 1'b1, restart = 1'b0;
  logic [NCH-1:0] clk_slw = '0;
  logic [SW-1:0]  ch_sel = '0;
  logic [CW-1:0]  ht_out, lt_out, ht3, lt3;
  logic [CW:0]    per_out, per_min, per_max, per3, min3, max3;
  logic           valid_out, vld3;
  logic [NCH-1:0] stopped, upd;
  logic [2:0]     stp3, upd3;

  clock_tester_multi #(.NUM_CH(NCH), .CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT(TMO), .SEL_W(SW)) dut (
    .clk_fst(clk_fst), .reset(reset), .restart(restart), .clk_slw(clk_slw), .ch_sel(ch_sel),
    .ht_out(ht_out), .lt_out(lt_out), .per_out(per_out), .per_min(per_min), .per_max(per_max),
    .valid_out(valid_out), .stopped(stopped), .upd(upd));

  clock_tester_multi #(.NUM_CH(3), .CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT(TMO), .SEL_W(SW)) dut3 (
    .clk_fst(clk_fst), .reset(reset), .restart(restart), .clk_slw(clk_slw[2:0]), .ch_sel(ch_sel),
    .ht_out(ht3), .lt_out(lt3), .per_out(per3), .per_min(min3), .per_max(max3),
    .valid_out(vld3), .stopped(stp3), .upd(upd3));

  always #5 clk_fst = ~clk_fst;

  int nchk = 0, nerr = 0, cyc = 0;
  int hi_len[NCH], lo_len[NCH], pcnt[NCH], n_upd[NCH];
  bit en[NCH], hold[NCH];
  // model state: timestamps of the last observed rise/fall per channel
  int t_r[NCH], t_f[NCH], last_edge[NCH];
  bit r_ok[NCH], f_ok[NCH], h_ok[NCH], e_vld[NCH];
  int e_ht[NCH], e_lt[NCH], e_per[NCH], e_min[NCH], e_max[NCH], e_upd[NCH];

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      r_ok[i] = 0; f_ok[i] = 0; h_ok[i] = 0; e_vld[i] = 0;
      e_ht[i] = 0; e_lt[i] = 0; e_per[i] = 0; e_min[i] = PMAX; e_max[i] = 0;
    end
  endfunction

  // t is the cycle after which the input changed; phase length = difference of edge times
  function automatic void model_edge(input int ch, input bit lv, input int t);
    int p;
    last_edge[ch] = t;
    if (!lv) begin
      h_ok[ch] = r_ok[ch];
      if (r_ok[ch]) e_ht[ch] = sat(t - t_r[ch]);
      f_ok[ch] = 1; t_f[ch] = t;
    end else begin
      if (f_ok[ch]) e_lt[ch] = sat(t - t_f[ch]);
      if (h_ok[ch]) begin
        p = e_ht[ch] + e_lt[ch];
        e_per[ch] = p;
        if (!e_vld[ch] || p < e_min[ch]) e_min[ch] = p;
        if (!e_vld[ch] || p > e_max[ch]) e_max[ch] = p;
        e_vld[ch] = 1;
        e_upd[ch]++;
      end
      r_ok[ch] = 1; t_r[ch] = t;
    end
  endfunction

  // slow-clock generator
  initial begin
    forever begin
      @(posedge clk_fst); #1;
      cyc++;
      for (int i = 0; i < NCH; i++) begin
        bit tg;
        tg = 0;
        if (en[i]) begin
          pcnt[i]++;
          if (pcnt[i] >= (clk_slw[i] ? hi_len[i] : lo_len[i])) tg = 1;
        end else if (clk_slw[i] != hold[i]) tg = 1;
        if (tg) begin
          clk_slw[i] = ~clk_slw[i];
          pcnt[i] = 0;
          model_edge(i, clk_slw[i], cyc);
        end
      end
    end
  end

  always @(negedge clk_fst)
    for (int i = 0; i < NCH; i++) if (upd[i]) n_upd[i]++;

  task automatic set_ch(input int ch, input int h, input int l);
    hi_len[ch] = h; lo_len[ch] = l; en[ch] = 1;
  endtask

  task automatic freeze();
    for (int i = 0; i < NCH; i++) begin hold[i] = clk_slw[i]; en[i] = 0; end
    repeat (6) @(negedge clk_fst);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NCH; i++) begin
      ch_sel = SW'(i);
      @(negedge clk_fst);
      chk($sformatf("%s ht ch%0d", tag, i), ht_out, e_ht[i]);
      chk($sformatf("%s lt ch%0d", tag, i), lt_out, e_lt[i]);
      chk($sformatf("%s per ch%0d", tag, i), per_out, e_per[i]);
      chk($sformatf("%s min ch%0d", tag, i), per_min, e_min[i]);
      chk($sformatf("%s max ch%0d", tag, i), per_max, e_max[i]);
      chk($sformatf("%s vld ch%0d", tag, i), valid_out, e_vld[i]);
      chk($sformatf("%s upd ch%0d", tag, i), n_upd[i], e_upd[i]);
    end
  endtask

  initial begin
    int te, k;
    for (int i = 0; i < NCH; i++) begin
      en[i] = 0; hold[i] = 0; hi_len[i] = 5; lo_len[i] = 5; pcnt[i] = 0; n_upd[i] = 0; e_upd[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk_fst);
    chk("rst ht", ht_out, 0);
    chk("rst per", per_out, 0);
    chk("rst per_min", per_min, PMAX);
    chk("rst per_max", per_max, 0);
    chk("rst valid", valid_out, 0);
    chk("rst upd", upd, 0);
    chk("rst stopped", stopped, 0);
    chk("rst stp3", stp3, 0);
    chk("rst upd3", upd3, 0);
    reset = 0;
    model_reset();

    set_ch(0, 2, 2); set_ch(1, 3, 3); set_ch(2, 4, 4); set_ch(3, 5, 5);
    repeat (80) @(negedge clk_fst);
    freeze();
    check_all("dir");

    set_ch(2, 3, 7);
    repeat (60) @(negedge clk_fst);
    freeze();
    check_all("ch2_37");
    set_ch(2, 6, 6);
    repeat (60) @(negedge clk_fst);
    freeze();
    check_all("ch2_66");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NCH; i++) set_ch(i, $urandom_range(1, 15), $urandom_range(1, 15));
      repeat ($urandom_range(40, 150)) @(negedge clk_fst);
      freeze();
      check_all($sformatf("rnd%0d", r));
    end

    // long high phase saturates the high counter
    set_ch(1, 3, 3);
    repeat (20) @(negedge clk_fst);
    hold[1] = 1; en[1] = 0;
    repeat (300) @(negedge clk_fst);
    hold[1] = 0;
    repeat (4) @(negedge clk_fst);
    hold[1] = 1;
    repeat (6) @(negedge clk_fst);
    ch_sel = 2'd1;
    @(negedge clk_fst);
    chk("sat ht", ht_out, 255);
    chk("sat lt", lt_out, 4);
    chk("sat per", per_out, 259);
    check_all("sat");

    // stopped detection on ch3
    set_ch(3, 4, 4);
    repeat (30) @(negedge clk_fst);
    hold[3] = 0; en[3] = 0;
    repeat (2) @(negedge clk_fst);
    te = last_edge[3];
    while (cyc < te + TMO + 2) @(negedge clk_fst);
    chk("stp early", stopped[3], 0);
    @(negedge clk_fst);
    chk("stp set", stopped[3], 1);
    check_all("stp");
    en[3] = 1;
    k = 0;
    while (last_edge[3] == te && k < 50) begin @(negedge clk_fst); k++; end
    chk("stp resume edge", int'(last_edge[3] != te), 1);
    te = last_edge[3];
    while (cyc < te + 2) @(negedge clk_fst);
    chk("stp hold", stopped[3], 1);
    @(negedge clk_fst);
    chk("stp clear", stopped[3], 0);
    freeze();

    // restart in the middle of a high phase
    set_ch(0, 5, 5);
    ch_sel = 2'd0;
    repeat (40) @(negedge clk_fst);
    k = 0;
    while (!(clk_slw[0] && pcnt[0] == 3) && k < 40) begin @(negedge clk_fst); k++; end
    chk("rs align", int'(clk_slw[0] && pcnt[0] == 3), 1);
    @(negedge clk_fst); restart = 1;
    @(negedge clk_fst); restart = 0;
    model_reset();
    chk("rs ht", ht_out, 0);
    chk("rs lt", lt_out, 0);
    chk("rs per", per_out, 0);
    chk("rs per_min", per_min, PMAX);
    chk("rs per_max", per_max, 0);
    chk("rs valid", valid_out, 0);
    repeat (8) @(negedge clk_fst);
    chk("rs valid late", valid_out, 0);
    repeat (32) @(negedge clk_fst);
    freeze();
    ch_sel = 2'd0;
    @(negedge clk_fst);
    chk("rs per new", per_out, 10);
    chk("rs3 per", per3, e_per[0]);
    check_all("rs");

    // unused selector code on the three-channel instance
    ch_sel = 2'd3;
    @(negedge clk_fst);
    chk("oor ht", ht3, 0);
    chk("oor lt", lt3, 0);
    chk("oor per", per3, 0);
    chk("oor min", min3, 0);
    chk("oor max", max3, 0);
    chk("oor vld", vld3, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
